branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences branch resolution for the 5-stage pipeline. Consumes the EX-stage branch
//  comparator result (beq/bne/blt/bge/bltu/bgeu) and the fetched direction prediction.
//  On a mispredict it issues a one-cycle PC redirect and runs a timed flush window.
//  Keeps resolved-branch and mispredict counters, and optionally a 2-bit BHT predictor.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush_o stays high after a mispredict (1..7)
//  BHT_ENTRIES   64  BHT depth, power of 2 (used only with BHT_EN)
//  XLEN          32  PC/target width
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  if_pc          in   XLEN  PC being fetched (BHT lookup)
//  if_pred_taken  out  1     predicted direction for if_pc
//  ex_valid       in   1     EX stage holds a live instruction
//  ex_stall       in   1     EX frozen this cycle
//  ex_is_branch   in   1     EX instruction is conditional branch
//  ex_is_jump     in   1     EX instruction is jal/jalr (always taken)
//  ex_cmp_taken   in   1     branch comparator output
//  ex_pred_taken  in   1     direction predicted at fetch, piped to EX
//  ex_pc          in   XLEN  PC of EX instruction
//  ex_target      in   XLEN  computed taken target
//  redirect_o     out  1     one-cycle PC redirect pulse
//  redirect_pc_o  out  XLEN  PC to fetch when redirect_o=1
//  flush_o        out  1     squash IF/ID and ID/EX contents
//  branch_cnt_o   out  32    resolved control-transfer count
//  mispred_cnt_o  out  32    mispredict count
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; flush counter 0; BHT entries = 2'b01.
//  resolve = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & (state==IDLE).
//  actual = ex_is_jump | (ex_is_branch & ex_cmp_taken); mispred = resolve & (actual != ex_pred_taken).
//  redirect_pc = actual ? ex_target : ex_pc + 4 (mod 2^XLEN, wraps silently).
//  FSM IDLE: mispred at cycle T -> FLUSH. At T+1: redirect_o=1 for exactly one cycle,
//   redirect_pc_o registered. flush_o=1 from T+1 through T+FLUSH_CYCLES.
//  FSM FLUSH: down-counter loaded with FLUSH_CYCLES, decrements every cycle regardless of
//   ex_stall; at 1 -> IDLE. EX inputs ignored (wrong path): no counts, no BHT update.
//  Correct prediction: no redirect, no flush, state stays IDLE.
//  branch_cnt_o +1 per resolve; mispred_cnt_o +1 per mispred; both registered, wrap 2^32-1 -> 0.
//  ex_is_branch & ex_is_jump both set: treated as jump.
//  redirect_pc_o holds its last value when redirect_o=0.
//  ex_stall=1 in IDLE: nothing resolves; a held branch resolves once, the cycle ex_stall drops.
//  Reset mid-flush: immediate return to IDLE, flush_o/redirect_o drop asynchronously.
// CONFIGURATION
//  BRANCH_BHT_EN defined:
//   - BHT_ENTRIES x 2-bit saturating counters, index if_pc[log2(BHT_ENTRIES)+1:2].
//   - if_pred_taken = counter[1], combinational read.
//   - Update on resolve & ex_is_branch (not jumps), indexed by ex_pc: +1 if taken, -1 if not,
//     saturating at 0/3.
//   - Same-cycle read/update of one index: read returns the pre-update value.
//  BRANCH_BHT_EN undefined: no BHT storage; if_pred_taken tied 0 (static not-taken).
//   Resolution, redirect and flush are unchanged.
// TESTING
//  1. Reset -> all outputs 0; with BHT_EN, if_pred_taken=0 for any if_pc.
//  2. beq taken, pred 0, ex_pc=0x100, ex_target=0x80
//     -> T+1 redirect_o=1, redirect_pc_o=0x80; flush_o high T+1..T+2; mispred_cnt_o=1.
//  3. bne not taken, pred 1, ex_pc=0xFFFFFFFC -> redirect_pc_o=0x00000000 (wrap).
//  4. Branch in EX during flush window -> ignored: counts unchanged, no second redirect.
//  5. jal with pred 1 -> no redirect; branch_cnt_o +1, mispred_cnt_o unchanged.
//     Same jal with ex_stall=1 for 3 cycles -> counted once.
//  6. BHT_EN: 2 taken resolves at pc 0x40 -> if_pc=0x40 predicts 1.
//     3 not-taken -> predicts 0; counter saturates at 0.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle between the EX/IF pipeline stages and the branch resolution controller.
// The controller uses the slave modport; the surrounding pipeline (or the bench) uses master.
// Carries fetch-side BHT lookup, EX-side resolution inputs, and redirect/flush/counter outputs.
interface branch_resolve_ctrl_if #(
  parameter int XLEN = 32
);
  // fetch-side prediction lookup
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  // EX-stage resolution inputs
  logic            ex_valid;
  logic            ex_stall;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic            ex_cmp_taken;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  // redirect / flush / statistics outputs
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_o;
  logic [31:0]     branch_cnt_o;
  logic [31:0]     mispred_cnt_o;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jump,
           ex_cmp_taken, ex_pred_taken, ex_pc, ex_target,
    input  if_pred_taken, redirect_o, redirect_pc_o, flush_o,
           branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jump,
           ex_cmp_taken, ex_pred_taken, ex_pc, ex_target,
    output if_pred_taken, redirect_o, redirect_pc_o, flush_o,
           branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: EX-stage mispredict detection, PC redirect, timed flush, counters.
// Latency: mispredict seen in cycle T -> redirect pulse and flush start in T+1; flush lasts FLUSH_CYCLES.
// No backpressure: ex_stall only defers resolution; the flush window counts down regardless of stalls.
// Optional 2-bit BHT predictor enabled by defining BRANCH_BHT_EN (otherwise static not-taken).
module branch_resolve_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_ENTRIES  = 64,
  parameter int XLEN         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolve_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_flush_cnt;
  logic [2:0]      w_flush_cnt_nxt;
  logic            w_flush;

  logic            w_resolve;
  logic            w_actual;
  logic            w_mispred;
  logic [XLEN-1:0] w_redirect_pc;

  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic [31:0]     r_branch_cnt;
  logic [31:0]     r_mispred_cnt;

  // Only resolve in IDLE: anything reaching EX during the flush window is wrong-path.
  assign w_resolve = bus.ex_valid & ~bus.ex_stall & (bus.ex_is_branch | bus.ex_is_jump)
                   & (r_state == S_IDLE);
  // A jump wins over the branch flag when both are set.
  assign w_actual  = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_cmp_taken);
  assign w_mispred = w_resolve & (w_actual != bus.ex_pred_taken);
  // Fall-through wraps silently at the top of the address space.
  assign w_redirect_pc = w_actual ? bus.ex_target : (bus.ex_pc + XLEN'(4));

  // State and flush down-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state logic: enter FLUSH on mispredict, leave when the counter reaches 1.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_flush         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mispred) begin
          w_state_nxt     = S_FLUSH;
          w_flush_cnt_nxt = 3'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        w_flush         = 1'b1;
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        if (r_flush_cnt <= 3'd1) begin
          w_state_nxt     = S_IDLE;
          w_flush_cnt_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Redirect pulse and target; the target is held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_mispred;
      if (w_mispred) begin
        r_redirect_pc <= w_redirect_pc;
      end
    end
  end

  // Resolved-transfer and mispredict statistics, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else begin
      if (w_resolve) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (w_mispred) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  // flush_o decodes the state register so reset removes it asynchronously.
  assign bus.flush_o       = w_flush;
  assign bus.redirect_o    = r_redirect;
  assign bus.redirect_pc_o = r_redirect_pc;
  assign bus.branch_cnt_o  = r_branch_cnt;
  assign bus.mispred_cnt_o = r_mispred_cnt;

`ifdef BRANCH_BHT_EN
  localparam int IDXW = $clog2(BHT_ENTRIES);

  logic [1:0]      r_bht [BHT_ENTRIES];
  logic [IDXW-1:0] w_if_idx;
  logic [IDXW-1:0] w_ex_idx;
  logic            w_bht_upd;

  assign w_if_idx  = bus.if_pc[IDXW+1:2];
  assign w_ex_idx  = bus.ex_pc[IDXW+1:2];
  // Jumps are always taken, so training on them would only pollute the table.
  assign w_bht_upd = w_resolve & bus.ex_is_branch & ~bus.ex_is_jump;
  // Combinational read sees the pre-update value on a same-index collision.
  assign bus.if_pred_taken = r_bht[w_if_idx][1];

  // Saturating 2-bit counter training, weakly-not-taken after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_upd) begin
      if (bus.ex_cmp_taken) begin
        if (r_bht[w_ex_idx] != 2'b11) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
        end
      end else begin
        if (r_bht[w_ex_idx] != 2'b00) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
        end
      end
    end
  end
`else
  // Static not-taken prediction.
  assign bus.if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a cycle-level behavioural model and per-cycle compare.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
// Define BRANCH_BHT_EN for both DUT and bench to exercise the predictor table.
module tb_branch_resolve_ctrl;
  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int NBHT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_resolve_ctrl #(
    .FLUSH_CYCLES(FC),
    .BHT_ENTRIES (NBHT),
    .XLEN        (XLEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total  = 0;
  int bad    = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int          m_flush_left = 0;
  bit          m_redir      = 1'b0;
  logic [31:0] m_rpc        = 32'd0;
  logic [31:0] m_bcnt       = 32'd0;
  logic [31:0] m_mcnt       = 32'd0;
  int          m_bht [NBHT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flush_left = 0;
      m_redir      = 1'b0;
      m_rpc        = 32'd0;
      m_bcnt       = 32'd0;
      m_mcnt       = 32'd0;
      for (int i = 0; i < NBHT; i++) m_bht[i] = 1;
    end else begin
      bit actual;
      int idx;
      m_redir = 1'b0;
      if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
      end else if (bus.ex_valid && !bus.ex_stall && (bus.ex_is_branch || bus.ex_is_jump)) begin
        actual = bus.ex_is_jump || bus.ex_cmp_taken;
        m_bcnt = m_bcnt + 32'd1;
        if (bus.ex_is_branch && !bus.ex_is_jump) begin
          idx = int'(bus.ex_pc[7:2]);
          if (actual) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
          else        m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
        end
        if (actual != bus.ex_pred_taken) begin
          m_mcnt       = m_mcnt + 32'd1;
          m_redir      = 1'b1;
          m_rpc        = actual ? bus.ex_target : bus.ex_pc + 32'd4;
          m_flush_left = FC;
        end
      end
    end
  end

  function automatic bit model_pred();
`ifdef BRANCH_BHT_EN
    return m_bht[int'(bus.if_pc[7:2])] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_redirect",    32'(bus.redirect_o),    32'(m_redir));
      chk("cyc_redirect_pc", bus.redirect_pc_o,      m_rpc);
      chk("cyc_flush",       32'(bus.flush_o),       32'(m_flush_left > 0));
      chk("cyc_branch_cnt",  bus.branch_cnt_o,       m_bcnt);
      chk("cyc_mispred_cnt", bus.mispred_cnt_o,      m_mcnt);
      chk("cyc_pred",        32'(bus.if_pred_taken), 32'(model_pred()));
    end
  end

  // ---------------- stimulus ----------------
  // flags = {valid, stall, is_branch, is_jump, cmp_taken, pred_taken}
  task automatic drv(input logic [5:0] flags, input logic [31:0] pc, input logic [31:0] tgt);
    @(posedge clk);
    #2;
    {bus.ex_valid, bus.ex_stall, bus.ex_is_branch, bus.ex_is_jump,
     bus.ex_cmp_taken, bus.ex_pred_taken} = flags;
    bus.ex_pc     = pc;
    bus.ex_target = tgt;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drv(6'b000000, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_pc = 32'h0;
    {bus.ex_valid, bus.ex_stall, bus.ex_is_branch, bus.ex_is_jump,
     bus.ex_cmp_taken, bus.ex_pred_taken} = 6'b0;
    bus.ex_pc     = 32'd0;
    bus.ex_target = 32'd0;

    // 1. reset state
    repeat (2) @(negedge clk);
    chk("rst_redirect",   32'(bus.redirect_o), 32'd0);
    chk("rst_rpc",        bus.redirect_pc_o,   32'd0);
    chk("rst_flush",      32'(bus.flush_o),    32'd0);
    chk("rst_bcnt",       bus.branch_cnt_o,    32'd0);
    chk("rst_mcnt",       bus.mispred_cnt_o,   32'd0);
    chk("rst_pred_0",     32'(bus.if_pred_taken), 32'd0);
    bus.if_pc = 32'h40;
    #1;
    chk("rst_pred_40",    32'(bus.if_pred_taken), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    idle_n(2);

    // 2. beq taken, predicted not taken
    drv(6'b101010, 32'h100, 32'h80);
    idle_n(1);
    @(negedge clk);
    chk("t2_redirect",   32'(bus.redirect_o), 32'd1);
    chk("t2_rpc",        bus.redirect_pc_o,   32'h80);
    chk("t2_flush_t1",   32'(bus.flush_o),    32'd1);
    chk("t2_mcnt",       bus.mispred_cnt_o,   32'd1);
    chk("t2_bcnt",       bus.branch_cnt_o,    32'd1);
    @(negedge clk);
    chk("t2_redirect_t2", 32'(bus.redirect_o), 32'd0);
    chk("t2_flush_t2",    32'(bus.flush_o),    32'd1);
    chk("t2_rpc_hold",    bus.redirect_pc_o,   32'h80);
    @(negedge clk);
    chk("t2_flush_t3",    32'(bus.flush_o),    32'd0);
    idle_n(2);

    // 3. bne not taken, predicted taken, fall-through wraps
    drv(6'b101001, 32'hFFFF_FFFC, 32'h10);
    idle_n(1);
    @(negedge clk);
    chk("t3_redirect", 32'(bus.redirect_o), 32'd1);
    chk("t3_rpc_wrap", bus.redirect_pc_o,   32'h0);
    chk("t3_mcnt",     bus.mispred_cnt_o,   32'd2);
    idle_n(3);

    // 4. wrong-path branch held in EX through the flush window
    drv(6'b101010, 32'h200, 32'h300);
    drv(6'b101010, 32'h400, 32'h500);
    drv(6'b101010, 32'h400, 32'h500);
    idle_n(1);
    @(negedge clk);
    chk("t4_bcnt",     bus.branch_cnt_o,    32'd3);
    chk("t4_mcnt",     bus.mispred_cnt_o,   32'd3);
    chk("t4_redirect", 32'(bus.redirect_o), 32'd0);
    chk("t4_rpc",      bus.redirect_pc_o,   32'h300);
    idle_n(2);

    // 5. jal predicted taken, then the same jal stalled 3 cycles
    drv(6'b100101, 32'h600, 32'h700);
    idle_n(1);
    @(negedge clk);
    chk("t5_bcnt",     bus.branch_cnt_o,    32'd4);
    chk("t5_mcnt",     bus.mispred_cnt_o,   32'd3);
    chk("t5_redirect", 32'(bus.redirect_o), 32'd0);
    repeat (3) drv(6'b110101, 32'h600, 32'h700);
    drv(6'b100101, 32'h600, 32'h700);
    idle_n(1);
    @(negedge clk);
    chk("t5_stall_once", bus.branch_cnt_o, 32'd5);

    // branch+jump together behaves as a jump (taken despite cmp=0)
    drv(6'b101101, 32'h800, 32'h900);
    idle_n(1);
    @(negedge clk);
    chk("t5_bj_bcnt", bus.branch_cnt_o,  32'd6);
    chk("t5_bj_mcnt", bus.mispred_cnt_o, 32'd3);

    // jump predicted not taken -> redirect to target
    drv(6'b100100, 32'hA00, 32'hB00);
    idle_n(1);
    @(negedge clk);
    chk("t5_jmp_rpc",  bus.redirect_pc_o,  32'hB00);
    chk("t5_jmp_mcnt", bus.mispred_cnt_o,  32'd4);
    idle_n(3);

    // 6. predictor training at pc 0x40
    bus.if_pc = 32'h40;
    repeat (2) drv(6'b101011, 32'h40, 32'h80);
    idle_n(1);
    @(negedge clk);
`ifdef BRANCH_BHT_EN
    chk("t6_pred_taken", 32'(bus.if_pred_taken), 32'd1);
`else
    chk("t6_static_nt",  32'(bus.if_pred_taken), 32'd0);
`endif
    repeat (3) drv(6'b101000, 32'h40, 32'h80);
    idle_n(1);
    @(negedge clk);
    chk("t6_pred_nt", 32'(bus.if_pred_taken), 32'd0);
    drv(6'b101000, 32'h40, 32'h80);
    drv(6'b101010, 32'h40, 32'h80);
    idle_n(FC + 1);
    @(negedge clk);
    chk("t6_sat_lo", 32'(bus.if_pred_taken), 32'd0);
    drv(6'b101011, 32'h40, 32'h80);
    idle_n(1);
    @(negedge clk);
`ifdef BRANCH_BHT_EN
    chk("t6_recover", 32'(bus.if_pred_taken), 32'd1);
`else
    chk("t6_recover", 32'(bus.if_pred_taken), 32'd0);
`endif
    idle_n(2);

    // reset in the middle of a flush window
    drv(6'b101010, 32'h1000, 32'h2000);
    idle_n(1);
    @(negedge clk);
    chk("rmf_flush_before", 32'(bus.flush_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmf_flush_async",    32'(bus.flush_o),    32'd0);
    chk("rmf_redirect_async", 32'(bus.redirect_o), 32'd0);
    chk("rmf_bcnt",           bus.branch_cnt_o,    32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle_n(2);
    @(negedge clk);
    chk("rmf_idle_after", 32'(bus.flush_o), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
